// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and deglitches both lines, deframes
// 11-bit frames, checks odd parity and stop bit, and folds E0/F0 prefixes into flags.
module ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       ext,
  output logic       brk,
  output logic       valid,
  output logic       err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clkSync_q, dataSync_q;
  logic [FW-1:0] clkCnt_q, dataCnt_q;
  logic          clkFilt_q, dataFilt_q, clkFiltPrev_q;

  state_t        state_q;
  logic [2:0]    bitCnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] toCnt_q;
  logic          extPend_q, brkPend_q;
  logic [7:0]    code_q;
  logic          ext_q, brk_q, valid_q, err_q;

  logic fall;
  logic bitIn;

  // A filtered level only moves after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      clkSync_q     <= 2'b11;
      dataSync_q    <= 2'b11;
      clkCnt_q      <= '0;
      dataCnt_q     <= '0;
      clkFilt_q     <= 1'b1;
      dataFilt_q    <= 1'b1;
      clkFiltPrev_q <= 1'b1;
    end else begin
      clkSync_q     <= {clkSync_q[0], ps2_clk};
      dataSync_q    <= {dataSync_q[0], ps2_data};
      clkFiltPrev_q <= clkFilt_q;

      if (clkSync_q[1] == clkFilt_q) begin
        clkCnt_q <= '0;
      end else if (clkCnt_q == FW'(FILTER_LEN - 1)) begin
        clkCnt_q  <= '0;
        clkFilt_q <= clkSync_q[1];
      end else begin
        clkCnt_q <= clkCnt_q + 1'b1;
      end

      if (dataSync_q[1] == dataFilt_q) begin
        dataCnt_q <= '0;
      end else if (dataCnt_q == FW'(FILTER_LEN - 1)) begin
        dataCnt_q  <= '0;
        dataFilt_q <= dataSync_q[1];
      end else begin
        dataCnt_q <= dataCnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    fall  = clkFiltPrev_q & ~clkFilt_q;
    bitIn = dataFilt_q;
  end

  // Timeout takes priority over a frame step; it fires one cycle before the count would hit TIMEOUT
  // so that err lands TIMEOUT+1 cycles after the last fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      toCnt_q   <= '0;
      extPend_q <= 1'b0;
      brkPend_q <= 1'b0;
      code_q    <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;

      if (state_q == IDLE || fall) toCnt_q <= '0;
      else                         toCnt_q <= toCnt_q + 1'b1;

      if (state_q != IDLE && !fall && toCnt_q == TW'(TIMEOUT - 1)) begin
        state_q   <= IDLE;
        err_q     <= 1'b1;
        extPend_q <= 1'b0;
        brkPend_q <= 1'b0;
      end else if (fall) begin
        case (state_q)
          IDLE: begin
            if (!bitIn) begin
              state_q  <= DATA;
              bitCnt_q <= '0;
              shift_q  <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
          DATA: begin
            shift_q <= {bitIn, shift_q[7:1]};
            if (bitCnt_q == 3'd7) state_q <= PARITY;
            else                  bitCnt_q <= bitCnt_q + 1'b1;
          end
          PARITY: begin
            parity_q <= bitIn;
            state_q  <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (bitIn && (^{parity_q, shift_q})) begin
              if (shift_q == 8'hE0) begin
                extPend_q <= 1'b1;
              end else if (shift_q == 8'hF0) begin
                brkPend_q <= 1'b1;
              end else begin
                code_q    <= shift_q;
                ext_q     <= extPend_q;
                brk_q     <= brkPend_q;
                valid_q   <= 1'b1;
                extPend_q <= 1'b0;
                brkPend_q <= 1'b0;
              end
            end else begin
              err_q     <= 1'b1;
              extPend_q <= 1'b0;
              brkPend_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign code  = code_q;
  assign ext   = ext_q;
  assign brk   = brk_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule
